sdram_port_arb: RTL and testbench
=================================

// Module: sdram_port_arb
//
// PURPOSE
//  Shares the single MiSTer SDRAM read/write command channel between NREQ requesters.
//  Typical requesters: CPU memory interface, ROM/BMP loader, CD-ROM DMA.
//  Arbitrates one transaction at a time (round-robin, optional port-0 priority),
//  latches its command, sequences the RD/WE strobe and RDY handshake, returns data.
//  Sits between the requesters and the SDRAM controller, entirely in the SDRAM clock domain.
//
// PARAMETERS
//  NREQ       3  number of requesters (2..8)
//  PRIO0      1  1: port 0 wins over round-robin whenever valid in IDLE
//  DROP_WAIT  4  cycles to wait in WDROP for RDY to fall before proceeding anyway
//
// PORTS
//  SDRAM_CLK     in   1        single clock
//  SDRAM_RESn    in   1        asynchronous active-low reset
//  REQ_VALID     in   NREQ     request; held high until REQ_DONE seen
//  REQ_WE        in   NREQ     1=write, 0=read
//  REQ_A         in   NREQ*25  byte address, port i at [25*i+:25]
//  REQ_DI        in   NREQ*32  write data, port i at [32*i+:32]
//  REQ_BE        in   NREQ*4   byte enables (active high), port i at [4*i+:4]
//  REQ_DONE      out  NREQ     one-cycle completion pulse to owner
//  REQ_DO        out  32       read data; valid with REQ_DONE, held until next read completes
//  GRANT         out  NREQ     one-hot current owner, 0 when idle
//  BUSY          out  1        transaction in progress (state != IDLE)
//  SDRAM_RADDR   out  25       read address
//  SDRAM_WADDR   out  25       write address
//  SDRAM_DIN     out  32       write data
//  SDRAM_BE      out  4        byte enables
//  SDRAM_RD      out  1        read strobe
//  SDRAM_WE      out  1        write strobe
//  SDRAM_RD_RDY  in   1        controller read channel idle/complete
//  SDRAM_WE_RDY  in   1        controller write channel idle/complete
//  SDRAM_DOUT    in   32       read data, valid when SDRAM_RD_RDY rises
//
// BEHAVIOUR
//  Reset values:
//   - All outputs registered; reset to 0. Rotation pointer LAST resets to NREQ-1.
//   - Reset mid-transaction: state returns to IDLE immediately; no REQ_DONE is issued.
//   - The in-flight controller op is abandoned and completes in the controller unobserved.
//  FSM states: IDLE, ISSUE, WDROP, WRDY, DONE.
//  IDLE:
//   - If any REQ_VALID, select a winner and latch A/DI/BE/WE.
//   - GRANT <= onehot(winner); go to ISSUE.
//   - Selection: PRIO0=1 and VALID[0] -> port 0. Otherwise first valid port scanning LAST+1, LAST+2, ... mod NREQ.
//  ISSUE:
//   - If the matching RDY (RD_RDY for read, WE_RDY for write) is high: drive SDRAM_RD or SDRAM_WE high for exactly this cycle, go to WDROP.
//   - If RDY is low: no strobe, remain in ISSUE.
//  WDROP:
//   - Wait for matching RDY low, then go to WRDY.
//   - If RDY stays high for DROP_WAIT cycles, go to WRDY anyway (controller finished instantly).
//  WRDY:
//   - Wait for matching RDY high.
//   - On that cycle, read: REQ_DO <= SDRAM_DOUT. LAST <= owner. Go to DONE.
//  DONE:
//   - REQ_DONE[owner]=1 for one cycle. GRANT <= 0. Go to IDLE.
//   - Requester may drop VALID on the edge that samples DONE.
//   - VALID seen in the following IDLE is a new request.
//  Address and data:
//   - RADDR and WADDR both carry the latched address; DIN and BE are latched values.
//   - All are stable from the ISSUE entry until DONE; no width conversion.
//  Strobe rules:
//   - SDRAM_RD and SDRAM_WE are never both high.
//   - At most one strobe per transaction.
//  Latency:
//   - VALID (cycle 0) -> strobe at cycle 1 if RDY high.
//   - REQ_DONE occurs 1 cycle after the RDY rise in WRDY.
//  Inputs:
//   - VALID dropping before DONE is a protocol violation; the latched transaction still completes.
//   - Non-owner VALIDs are ignored until IDLE.
//
// TESTING
//  1. Port1 read A=0x0012340, RD_RDY low 3 cycles after strobe, DOUT=0xDEADBEEF
//     -> one RD pulse, RADDR=0x0012340, DONE[1] single pulse, REQ_DO=0xDEADBEEF.
//  2. PRIO0=0, VALID=3'b111 held continuously -> grant order 0,1,2,0; each DONE exactly once per grant.
//  3. PRIO0=1, ports 1,2 continuous, port0 raised mid-transaction
//     -> port0 granted at next IDLE, ahead of rotation.
//  4. Port2 write DI=0xA5A5A5A5 BE=4'b0110 with WE_RDY low 5 cycles at ISSUE
//     -> no WE until WE_RDY high, then single WE with DIN/BE/WADDR correct.
//  5. RDY never drops after strobe -> WRDY entered after DROP_WAIT=4 cycles; DONE next cycle after RDY is seen high.
//  6. SDRAM_RESn asserted during WRDY
//     -> GRANT, BUSY, RD/WE, DONE at 0 immediately, no DONE pulse; first request after reset with VALID=3'b110 grants port 1.

Source files
------------

// File: rtl/sdram_port_arb.sv
// sdram_port_arb
//   Shares one SDRAM read/write command channel between NREQ requesters.
//   One transaction at a time: arbitrate (round-robin, optional port-0
//   priority), latch the command, sequence the RD/WE strobe against the
//   controller RDY handshake, then pulse REQ_DONE to the owner.
//
// Ports
//   SDRAM_CLK, SDRAM_RESn    clock, asynchronous active-low reset
//   REQ_VALID/WE [NREQ]      per-port request and direction (1 = write)
//   REQ_A  [NREQ*25]         per-port byte address, port i at [25*i+:25]
//   REQ_DI [NREQ*32]         per-port write data, port i at [32*i+:32]
//   REQ_BE [NREQ*4]          per-port byte enables, port i at [4*i+:4]
//   REQ_DONE [NREQ]          one-cycle completion pulse to the owner
//   REQ_DO [32]              last read data, held until the next read completes
//   GRANT [NREQ], BUSY       one-hot owner / transaction in progress
//   SDRAM_RADDR/WADDR/DIN/BE latched command towards the controller
//   SDRAM_RD, SDRAM_WE       one-cycle command strobes
//   SDRAM_RD_RDY/WE_RDY      controller channel idle/complete
//   SDRAM_DOUT               read data, valid when SDRAM_RD_RDY rises
module sdram_port_arb #(
   parameter int unsigned NREQ      = 3,
   parameter int unsigned PRIO0     = 1,
   parameter int unsigned DROP_WAIT = 4
) (
   input  logic             SDRAM_CLK,
   input  logic             SDRAM_RESn,
   input  logic [NREQ-1:0]    REQ_VALID,
   input  logic [NREQ-1:0]    REQ_WE,
   input  logic [NREQ*25-1:0] REQ_A,
   input  logic [NREQ*32-1:0] REQ_DI,
   input  logic [NREQ*4-1:0]  REQ_BE,
   output logic [NREQ-1:0]    REQ_DONE,
   output logic [31:0]        REQ_DO,
   output logic [NREQ-1:0]    GRANT,
   output logic               BUSY,
   output logic [24:0]        SDRAM_RADDR,
   output logic [24:0]        SDRAM_WADDR,
   output logic [31:0]        SDRAM_DIN,
   output logic [3:0]         SDRAM_BE,
   output logic               SDRAM_RD,
   output logic               SDRAM_WE,
   input  logic               SDRAM_RD_RDY,
   input  logic               SDRAM_WE_RDY,
   input  logic [31:0]        SDRAM_DOUT
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(DROP_WAIT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WDROP,
      S_WRDY,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [IW-1:0]     last_q, last_d;
   logic              we_q, we_d;
   logic [24:0]       addr_q, addr_d;
   logic [31:0]       din_q, din_d;
   logic [3:0]        be_q, be_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic              busy_q, busy_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [31:0]       do_q, do_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic              win_found;
   logic [IW-1:0]     win_idx;
   logic [IW:0]       scan;
   logic              rdy_cur;
   logic              rdy_win;

   // Winner selection: port 0 first when prioritised, else scan from LAST+1.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan      = '0;
      if (PRIO0 != 0 && REQ_VALID[0]) begin
         win_found = 1'b1;
      end else begin
         for (int unsigned k = 1; k <= NREQ; k++) begin
            scan = (IW+1)'(last_q) + (IW+1)'(k);
            if (scan >= (IW+1)'(NREQ)) begin
               scan = scan - (IW+1)'(NREQ);
            end
            if (!win_found && REQ_VALID[scan[IW-1:0]]) begin
               win_found = 1'b1;
               win_idx   = scan[IW-1:0];
            end
         end
      end
   end

   assign rdy_cur = we_q ? SDRAM_WE_RDY : SDRAM_RD_RDY;
   assign rdy_win = REQ_WE[win_idx] ? SDRAM_WE_RDY : SDRAM_RD_RDY;

   // The strobes are registered, so the decision to fire is taken one cycle
   // ahead on the RDY seen then: from IDLE for the winner, or in ISSUE while
   // no strobe is out yet. ISSUE leaves on the cycle the strobe is high.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      din_d   = din_q;
      be_d    = be_q;
      grant_d = grant_q;
      done_d  = '0;
      do_d    = do_q;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (win_found) begin
               owner_d = win_idx;
               we_d    = REQ_WE[win_idx];
               addr_d  = REQ_A[25*win_idx +: 25];
               din_d   = REQ_DI[32*win_idx +: 32];
               be_d    = REQ_BE[4*win_idx +: 4];
               grant_d = NREQ'(1) << win_idx;
               rd_d    = !REQ_WE[win_idx] && rdy_win;
               wr_d    = REQ_WE[win_idx] && rdy_win;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (rd_q || wr_q) begin
               cnt_d   = '0;
               state_d = S_WDROP;
            end else if (rdy_cur) begin
               rd_d = !we_q;
               wr_d = we_q;
            end
         end
         S_WDROP: begin
            // A controller that completes instantly never shows RDY low.
            if (!rdy_cur || cnt_q == CW'(DROP_WAIT - 1)) begin
               state_d = S_WRDY;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WRDY: begin
            if (rdy_cur) begin
               if (!we_q) begin
                  do_d = SDRAM_DOUT;
               end
               last_d          = owner_q;
               done_d[owner_q] = 1'b1;
               state_d         = S_DONE;
            end
         end
         S_DONE: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge SDRAM_CLK or negedge SDRAM_RESn) begin
      if (!SDRAM_RESn) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         last_q  <= IW'(NREQ - 1);
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         be_q    <= '0;
         grant_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= '0;
         do_q    <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         be_q    <= be_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         do_q    <= do_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign REQ_DONE    = done_q;
   assign REQ_DO      = do_q;
   assign GRANT       = grant_q;
   assign BUSY        = busy_q;
   assign SDRAM_RADDR = addr_q;
   assign SDRAM_WADDR = addr_q;
   assign SDRAM_DIN   = din_q;
   assign SDRAM_BE    = be_q;
   assign SDRAM_RD    = rd_q;
   assign SDRAM_WE    = wr_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb
//   Directed bench for sdram_port_arb. Instance 0 uses PRIO0=1, instance 1
//   uses PRIO0=0. Each instance has a small controller model: after a strobe
//   its RDY goes low for lat[u] cycles (or stays high when stuck[u]), and
//   hold_rd/hold_we force a channel's RDY low.
module tb_sdram_port_arb;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  valid  [2];
   logic [2:0]  req_we [2];
   logic [74:0] req_a  [2];
   logic [95:0] req_di [2];
   logic [11:0] req_be [2];
   logic [2:0]  done   [2];
   logic [31:0] req_do [2];
   logic [2:0]  grant  [2];
   logic        busy   [2];
   logic [24:0] raddr  [2];
   logic [24:0] waddr  [2];
   logic [31:0] din    [2];
   logic [3:0]  be_o   [2];
   logic        rd     [2];
   logic        wr     [2];
   logic        rd_rdy [2];
   logic        we_rdy [2];
   logic [31:0] dout   [2];

   int          lat    [2];
   bit          stuck  [2];
   bit          hold_rd[2];
   bit          hold_we[2];
   logic [31:0] dout_v [2];

   logic        rrd    [2] = '{1'b1, 1'b1};
   int          cnt    [2] = '{0, 0};

   int          rd_cyc [2] = '{0, 0};
   int          wr_cyc [2] = '{0, 0};
   int          done_cyc[2] = '{0, 0};
   int          both_hi[2] = '{0, 0};

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      sdram_port_arb #(
         .NREQ     (3),
         .PRIO0    ((g == 0) ? 1 : 0),
         .DROP_WAIT(4)
      ) u_dut (
         .SDRAM_CLK   (clk),
         .SDRAM_RESn  (rst_n),
         .REQ_VALID   (valid[g]),
         .REQ_WE      (req_we[g]),
         .REQ_A       (req_a[g]),
         .REQ_DI      (req_di[g]),
         .REQ_BE      (req_be[g]),
         .REQ_DONE    (done[g]),
         .REQ_DO      (req_do[g]),
         .GRANT       (grant[g]),
         .BUSY        (busy[g]),
         .SDRAM_RADDR (raddr[g]),
         .SDRAM_WADDR (waddr[g]),
         .SDRAM_DIN   (din[g]),
         .SDRAM_BE    (be_o[g]),
         .SDRAM_RD    (rd[g]),
         .SDRAM_WE    (wr[g]),
         .SDRAM_RD_RDY(rd_rdy[g]),
         .SDRAM_WE_RDY(we_rdy[g]),
         .SDRAM_DOUT  (dout[g])
      );
   end

   always_comb begin
      for (int u = 0; u < 2; u++) begin
         rd_rdy[u] = rrd[u] & ~hold_rd[u];
         we_rdy[u] = rrd[u] & ~hold_we[u];
         dout[u]   = rd_rdy[u] ? dout_v[u] : 32'h0BAD0BAD;
      end
   end

   // Controller model.
   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (rd[u] || wr[u]) begin
            if (!stuck[u]) begin
               rrd[u] <= 1'b0;
               cnt[u] <= lat[u];
            end
         end else if (!rrd[u]) begin
            if (cnt[u] <= 1) rrd[u] <= 1'b1;
            else             cnt[u] <= cnt[u] - 1;
         end
      end
   end

   // Activity counters.
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (rd[u])          rd_cyc[u]   <= rd_cyc[u] + 1;
         if (wr[u])          wr_cyc[u]   <= wr_cyc[u] + 1;
         if (done[u] != 0)   done_cyc[u] <= done_cyc[u] + 1;
         if (rd[u] && wr[u]) both_hi[u]  <= both_hi[u] + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input int u, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done[u] == 0 && n < 64);
   endtask

   int n, r0, w0, d0;
   logic [2:0] exp2 [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

   initial begin
      for (int u = 0; u < 2; u++) begin
         valid[u]   = '0;
         req_we[u]  = '0;
         req_a[u]   = {25'h1555555, 25'h0000000, 25'h0AAAAAA};
         req_di[u]  = {32'h11111111, 32'h22222222, 32'h33333333};
         req_be[u]  = 12'hFFF;
         lat[u]     = 1;
         stuck[u]   = 1'b0;
         hold_rd[u] = 1'b0;
         hold_we[u] = 1'b0;
         dout_v[u]  = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_grant",  grant[0], 3'b000);
      check("rst_busy",   busy[0],  1'b0);
      check("rst_rd",     rd[0],    1'b0);
      check("rst_we",     wr[0],    1'b0);
      check("rst_done",   done[0],  3'b000);
      check("rst_do",     req_do[0], 32'h0);
      check("rst_grant1", grant[1], 3'b000);
      rst_n = 1'b1;
      @(negedge clk);

      // Port 1 read, RDY low 3 cycles after the strobe.
      lat[0]    = 3;
      dout_v[0] = 32'hDEADBEEF;
      r0        = rd_cyc[0];
      req_a[0][25 +: 25] = 25'h0012340;
      req_we[0] = 3'b000;
      valid[0]  = 3'b010;
      @(negedge clk);
      check("t1_rd",    rd[0],    1'b1);
      check("t1_raddr", raddr[0], 25'h0012340);
      check("t1_grant", grant[0], 3'b010);
      check("t1_busy",  busy[0],  1'b1);
      wait_done(0, n);
      valid[0] = 3'b000;
      check("t1_lat",  n,         5);
      check("t1_done", done[0],   3'b010);
      check("t1_do",   req_do[0], 32'hDEADBEEF);
      @(negedge clk);
      check("t1_pulse", done[0],  3'b000);
      check("t1_idle",  grant[0], 3'b000);
      check("t1_rdcnt", rd_cyc[0] - r0, 1);

      // Port 2 write with WE_RDY held low while in ISSUE.
      hold_we[0] = 1'b1;
      lat[0]     = 2;
      w0         = wr_cyc[0];
      req_a[0][50 +: 25]  = 25'h1ABCDE0;
      req_di[0][64 +: 32] = 32'hA5A5A5A5;
      req_be[0][8 +: 4]   = 4'b0110;
      req_we[0] = 3'b100;
      valid[0]  = 3'b100;
      repeat (5) @(negedge clk);
      check("t4_early", wr_cyc[0] - w0, 0);
      hold_we[0] = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!wr[0] && n < 20);
      check("t4_wait",  n,        1);
      check("t4_we",    wr[0],    1'b1);
      check("t4_rd",    rd[0],    1'b0);
      check("t4_waddr", waddr[0], 25'h1ABCDE0);
      check("t4_din",   din[0],   32'hA5A5A5A5);
      check("t4_be",    be_o[0],  4'b0110);
      wait_done(0, n);
      valid[0] = 3'b000;
      check("t4_lat",  n,         4);
      check("t4_done", done[0],   3'b100);
      check("t4_do",   req_do[0], 32'hDEADBEEF);
      @(negedge clk);
      check("t4_wecnt", wr_cyc[0] - w0, 1);
      req_we[0] = 3'b000;

      // RDY never drops after the strobe: WDROP times out.
      stuck[0]  = 1'b1;
      dout_v[0] = 32'h12345678;
      valid[0]  = 3'b001;
      @(negedge clk);
      check("t5_rd",    rd[0],    1'b1);
      check("t5_grant", grant[0], 3'b001);
      check("t5_raddr", raddr[0], 25'h0AAAAAA);
      wait_done(0, n);
      valid[0] = 3'b000;
      check("t5_lat",  n,         6);
      check("t5_done", done[0],   3'b001);
      check("t5_do",   req_do[0], 32'h12345678);
      stuck[0] = 1'b0;
      @(negedge clk);

      // Priority: ports 1,2 continuous, port 0 raised mid-transaction.
      lat[0]   = 1;
      valid[0] = 3'b110;
      @(negedge clk);
      check("t3_first", grant[0], 3'b010);
      valid[0][0] = 1'b1;
      wait_done(0, n);
      check("t3_done1", done[0], 3'b010);
      wait_done(0, n);
      valid[0] = 3'b000;
      check("t3_done0",  done[0],  3'b001);
      check("t3_grant0", grant[0], 3'b001);
      @(negedge clk);

      // Round robin without priority on instance 1.
      lat[1]   = 1;
      valid[1] = 3'b111;
      for (int i = 0; i < 4; i++) begin
         wait_done(1, n);
         if (i == 3) valid[1] = 3'b000;
         check("t2_done",  done[1],  exp2[i]);
         check("t2_grant", grant[1], exp2[i]);
         @(negedge clk);
         check("t2_pulse", done[1], 3'b000);
      end
      check("t2_count", done_cyc[1], 4);

      // Reset asserted while in WRDY.
      lat[0]   = 10;
      valid[0] = 3'b100;
      @(negedge clk);
      check("t6_rd", rd[0], 1'b1);
      repeat (2) @(negedge clk);
      d0    = done_cyc[0];
      rst_n = 1'b0;
      #1;
      check("t6_grant", grant[0], 3'b000);
      check("t6_busy",  busy[0],  1'b0);
      check("t6_rd0",   rd[0],    1'b0);
      check("t6_we0",   wr[0],    1'b0);
      check("t6_done0", done[0],  3'b000);
      valid[0] = 3'b110;
      lat[0]   = 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t6_nodone", done_cyc[0] - d0, 0);
      check("t6_grant1", grant[0], 3'b010);
      wait_done(0, n);
      valid[0] = 3'b000;
      check("t6_done1", done[0], 3'b010);
      @(negedge clk);

      check("strobe_excl", both_hi[0] + both_hi[1], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
